// File: rtl/line_rotator_gen.sv
// rtl/line_rotator_gen.sv - line-rotation scrambler/descrambler for a BT.656 sample stream
//
// Double-buffers one video line and re-emits it one line later, cyclically
// rotated by a cut position captured at each line start. MODE 0 rotates the
// read address (scramble), MODE 1 rotates the write address (descramble).
// Optional feature macro: LINE_ROTATOR_LEN_CHECK_EN (adds line_len_err).
//
// Ports:
//   clk          sample clock
//   reset        asynchronous active-high reset
//   data_in      input sample
//   cut_position rotation offset, captured at line start (H falling)
//   V, H         vertical / horizontal blanking flags
//   data_out     rotated sample, registered
//   data_valid   data_out carries a primed line
//   cut_err      1-cycle pulse when the captured cut_position >= ACTIVE_LEN
//   line_len_err 1-cycle pulse when the ending line's active count != ACTIVE_LEN
//                (only with LINE_ROTATOR_LEN_CHECK_EN)
module line_rotator_gen #(
  parameter int DATA_W      = 10,
  parameter int ACTIVE_LEN  = 1440,
  parameter int ADDR_W      = 11,
  parameter int MODE        = 0,
  parameter int PRIME_LINES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] data_in,
  input  logic [ADDR_W-1:0] cut_position,
  input  logic              V,
  input  logic              H,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
`ifdef LINE_ROTATOR_LEN_CHECK_EN
  output logic              line_len_err,
`endif
  output logic              cut_err
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] IDX_MAX = {ADDR_W{1'b1}};
  localparam logic [ADDR_W:0]   LEN_W   = (ADDR_W+1)'(ACTIVE_LEN);

  typedef enum logic [1:0] {WAIT_SYNC, PRIME, RUN} state_t;

  state_t            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic              h_q, h_d;
  logic              bank_q, bank_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [ADDR_W-1:0] cut_q, cut_d;
  logic [DATA_W-1:0] data_out_q, data_out_d;
  logic              data_valid_q, data_valid_d;
  logic              cut_err_q, cut_err_d;

  // Two banks share one array; the bank bit is the address MSB.
  logic [DATA_W-1:0] mem [2*DEPTH];

  logic              ls;
  logic              bank_cur;
  logic [ADDR_W-1:0] idx_cur, cut_cur;
  logic              cut_bad, rot_en, wr_en;
  logic [ADDR_W:0]   sum, sum_wrap;
  logic [ADDR_W-1:0] r_addr, wr_addr, rd_addr;

  always_comb begin
    ls       = !H && h_q;
    // On the line-start cycle the new bank, index 0 and new cut apply at once.
    idx_cur  = ls ? '0 : idx_q;
    bank_cur = ls ? ~bank_q : bank_q;
    cut_bad  = {1'b0, cut_position} >= LEN_W;
    cut_cur  = ls ? (cut_bad ? '0 : cut_position) : cut_q;
    rot_en   = ({1'b0, idx_cur} < LEN_W) && !H && !V;
    // cut < ACTIVE_LEN, so one conditional subtraction is enough.
    sum      = {1'b0, idx_cur} + {1'b0, cut_cur};
    sum_wrap = (sum >= LEN_W) ? (sum - LEN_W) : sum;
    r_addr   = rot_en ? sum_wrap[ADDR_W-1:0] : idx_cur;
    wr_addr  = (MODE == 0) ? idx_cur : r_addr;
    rd_addr  = (MODE == 0) ? r_addr : idx_cur;
    wr_en    = (idx_cur != IDX_MAX);

    h_d        = H;
    bank_d     = bank_cur;
    cut_d      = cut_cur;
    idx_d      = (idx_cur == IDX_MAX) ? idx_cur : idx_cur + ADDR_W'(1);
    data_out_d = mem[{~bank_cur, rd_addr}];
    cut_err_d  = ls && cut_bad;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      WAIT_SYNC: if (ls) begin
        state_d = PRIME;
        cnt_d   = '0;
      end
      PRIME: if (ls) begin
        cnt_d = cnt_q + 3'd1;
        if (cnt_q + 3'd1 == 3'(PRIME_LINES)) state_d = RUN;
      end
      RUN:     state_d = RUN;
      default: state_d = WAIT_SYNC;
    endcase
    data_valid_d = (state_d == RUN);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= WAIT_SYNC;
      cnt_q        <= '0;
      h_q          <= 1'b0;
      bank_q       <= 1'b0;
      idx_q        <= '0;
      cut_q        <= '0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      cut_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      h_q          <= h_d;
      bank_q       <= bank_d;
      idx_q        <= idx_d;
      cut_q        <= cut_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      cut_err_q    <= cut_err_d;
    end
  end

  // Line buffer is deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[{bank_cur, wr_addr}] <= data_in;
  end

  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;
  assign cut_err    = cut_err_q;

`ifdef LINE_ROTATOR_LEN_CHECK_EN
  localparam logic [ADDR_W:0] ACT_MAX = {(ADDR_W+1){1'b1}};

  logic [ADDR_W:0] act_q, act_d;
  logic            len_err_q, len_err_d;

  // act_q counts !H cycles since the last line start; it saturates above
  // ACTIVE_LEN so an overlong line still reads as a mismatch.
  always_comb begin
    if (ls)                       act_d = (ADDR_W+1)'(1);
    else if (!H && act_q != ACT_MAX) act_d = act_q + (ADDR_W+1)'(1);
    else                          act_d = act_q;
    len_err_d = ls && (state_q != WAIT_SYNC) && (act_q != LEN_W);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      act_q     <= '0;
      len_err_q <= 1'b0;
    end else begin
      act_q     <= act_d;
      len_err_q <= len_err_d;
    end
  end

  assign line_len_err = len_err_q;
`endif

endmodule

// File: tb/tb_line_rotator_gen.sv
// tb/tb_line_rotator_gen.sv - self-checking bench: scrambler chained into descrambler
module tb_line_rotator_gen;

  localparam int DW = 10;
  localparam int AL = 8;
  localparam int AW = 4;
  localparam int PL = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic [DW-1:0] s_data, s_out, d_data, d_out;
  logic [AW-1:0] s_cut, d_cut;
  logic          s_v, s_h, d_v, d_h;
  logic          s_valid, s_err, d_valid, d_err;
`ifdef LINE_ROTATOR_LEN_CHECK_EN
  logic          s_len_err, d_len_err;
`endif

  always #5 clk = ~clk;

  line_rotator_gen #(.DATA_W(DW), .ACTIVE_LEN(AL), .ADDR_W(AW), .MODE(0), .PRIME_LINES(PL)) u_scr (
    .clk(clk), .reset(reset), .data_in(s_data), .cut_position(s_cut), .V(s_v), .H(s_h),
    .data_out(s_out), .data_valid(s_valid),
`ifdef LINE_ROTATOR_LEN_CHECK_EN
    .line_len_err(s_len_err),
`endif
    .cut_err(s_err));

  line_rotator_gen #(.DATA_W(DW), .ACTIVE_LEN(AL), .ADDR_W(AW), .MODE(1), .PRIME_LINES(PL)) u_dsc (
    .clk(clk), .reset(reset), .data_in(d_data), .cut_position(d_cut), .V(d_v), .H(d_h),
    .data_out(d_out), .data_valid(d_valid),
`ifdef LINE_ROTATOR_LEN_CHECK_EN
    .line_len_err(d_len_err),
`endif
    .cut_err(d_err));

  int checks   = 0;
  int failures = 0;

  // Reference model: x1 = previous scrambler input line (-1 = unknown),
  // ydesc = what the descrambler will emit this line.
  int j;
  int x1[8];
  int ydesc[8];
  int last_out[8];
  int err_cnt;
  int last_act;

  typedef struct {
    logic [AW-1:0] cut;
    logic          v;
    int            exp_err;
    int            exp[8];
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d (line %0d)", name, act, exp, j);
    end
  endtask

  // One clock: descrambler sees the scrambler's registered output and
  // one-cycle-delayed controls, so both units share the same line timing.
  task automatic step(input logic [DW-1:0] din, input logic [AW-1:0] cut, input logic v, input logic h);
    @(negedge clk);
    d_data = s_out; d_cut = s_cut; d_v = s_v; d_h = s_h;
    s_data = din;   s_cut = cut;   s_v = v;   s_h = h;
    @(posedge clk);
    #1;
  endtask

  task automatic run_line(input int act_len, input logic [AW-1:0] cut, input logic v, input int data[32]);
    int cur[8];
    int ynew[8];
    int ce, e, m;
    j++;
    err_cnt = 0;
    ce = (cut >= AL) ? 0 : int'(cut);
    for (int k = 0; k < 8; k++) cur[k] = (k < act_len) ? data[k] : -1;
    for (int i = 0; i < act_len + 4; i++) begin
      step((i < act_len) ? DW'(data[i]) : '0, cut, v, i >= act_len);
      if (s_err) err_cnt++;
      chk("s_valid", s_valid, j >= PL + 1);
      chk("d_valid", d_valid, (j > PL + 1) || (j == PL + 1 && i >= 1));
      chk("s_cut_err", s_err, i == 0 && cut >= AL);
      chk("d_cut_err", d_err, i == 1 && cut >= AL);
`ifdef LINE_ROTATOR_LEN_CHECK_EN
      chk("s_len_err", s_len_err, i == 0 && j >= 2 && last_act != AL);
      chk("d_len_err", d_len_err, i == 1 && j >= 2 && last_act != AL);
`endif
      if (i < act_len && i < 8 && j >= PL + 1) begin
        e = x1[v ? i : (i + ce) % AL];
        last_out[i] = int'(s_out);
        if (e >= 0) chk("s_data", s_out, e);
      end
      if (i >= 1 && i <= 8 && j >= PL + 1) begin
        e = ydesc[i-1];
        if (e >= 0) chk("d_data", d_out, e);
      end
    end
    // Descrambler restores x1 at the addresses it rotated into this line;
    // blanking cycles below ACTIVE_LEN overwrite their own addresses.
    for (int k = 0; k < 8; k++) ynew[k] = -1;
    for (int k = 0; k < act_len && k < 8; k++) begin
      m = v ? k : (k + ce) % AL;
      ynew[m] = x1[m];
    end
    for (int k = act_len; k < 8; k++) ynew[k] = -1;
    ydesc    = ynew;
    x1       = cur;
    last_act = act_len;
  endtask

  task automatic restart_model();
    j = 0;
    last_act = 0;
    for (int k = 0; k < 8; k++) begin x1[k] = -1; ydesc[k] = -1; end
  endtask

  initial begin
    vec_t tbl[7];
    int   ramp[32];
    int   rnd[32];

    tbl[0] = '{4'd3, 1'b0, 0, '{3, 4, 5, 6, 7, 0, 1, 2}};
    tbl[1] = '{4'd9, 1'b0, 1, '{0, 1, 2, 3, 4, 5, 6, 7}};
    tbl[2] = '{4'd5, 1'b1, 0, '{0, 1, 2, 3, 4, 5, 6, 7}};
    tbl[3] = '{4'd5, 1'b0, 0, '{5, 6, 7, 0, 1, 2, 3, 4}};
    tbl[4] = '{4'd7, 1'b0, 0, '{7, 0, 1, 2, 3, 4, 5, 6}};
    tbl[5] = '{4'd8, 1'b0, 1, '{0, 1, 2, 3, 4, 5, 6, 7}};
    tbl[6] = '{4'd0, 1'b0, 0, '{0, 1, 2, 3, 4, 5, 6, 7}};
    for (int k = 0; k < 32; k++) ramp[k] = k;

    restart_model();
    reset = 1'b1;
    s_data = '0; s_cut = '0; s_v = 1'b0; s_h = 1'b1;
    d_data = '0; d_cut = '0; d_v = 1'b0; d_h = 1'b1;
    #12;
    chk("rst_s_out", s_out, 0);
    chk("rst_s_valid", s_valid, 0);
    chk("rst_s_err", s_err, 0);
    chk("rst_d_out", d_out, 0);
    chk("rst_d_valid", d_valid, 0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step('0, '0, 1'b0, 1'b1);
      chk("idle_valid", s_valid, 0);
    end

    // Priming with ramp lines, then the directed table.
    for (int n = 0; n < 3; n++) run_line(AL, 4'd0, 1'b0, ramp);
    for (int t = 0; t < 7; t++) begin
      run_line(AL, tbl[t].cut, tbl[t].v, ramp);
      for (int k = 0; k < 8; k++) chk($sformatf("tbl%0d_out%0d", t, k), last_out[k], tbl[t].exp[k]);
      chk($sformatf("tbl%0d_err_pulses", t), err_cnt, tbl[t].exp_err);
    end

    // Random lines against the model.
    for (int n = 0; n < 20; n++) begin
      for (int k = 0; k < 32; k++) rnd[k] = int'($urandom_range(0, 1023));
      run_line(AL, AW'($urandom_range(0, 11)), ($urandom_range(0, 4) == 0), rnd);
    end

    // Overlong line: index saturates, later samples must not wrap onto 0..
    for (int k = 0; k < 32; k++) rnd[k] = 500 + k;
    run_line(20, 4'd2, 1'b0, rnd);
    run_line(AL, 4'd6, 1'b0, ramp);
    run_line(AL, 4'd1, 1'b0, ramp);

    // Short line: tail locations are stale and skipped by the model.
    for (int k = 0; k < 32; k++) rnd[k] = 900 + k;
    run_line(6, 4'd3, 1'b0, rnd);
    run_line(AL, 4'd4, 1'b0, ramp);
    run_line(AL, 4'd0, 1'b0, ramp);

    // Asynchronous reset mid-line while running.
    for (int i = 0; i < 5; i++) step(DW'(i + 1), 4'd2, 1'b0, 1'b0);
    chk("pre_rst_valid", s_valid, 1);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_s_valid", s_valid, 0);
    chk("mid_rst_s_out", s_out, 0);
    chk("mid_rst_d_valid", d_valid, 0);
    chk("mid_rst_d_out", d_out, 0);
    step('0, '0, 1'b0, 1'b1);
    @(negedge clk);
    reset = 1'b0;
    restart_model();
    for (int i = 0; i < 3; i++) step('0, '0, 1'b0, 1'b1);
    for (int n = 0; n < 5; n++) begin
      for (int k = 0; k < 32; k++) rnd[k] = int'($urandom_range(0, 1023));
      run_line(AL, AW'($urandom_range(0, 9)), 1'b0, rnd);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
